// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-requester (memory stage / program loader) arbiter in front of
//            a word-addressed 64-bit data memory, with loader anti-starvation.
// Revision : 1.0
// ============================================================================
module dmem_arbiter #(
  parameter int DEPTH      = 2048,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_req,
  input  logic        m_we,
  input  logic [63:0] m_addr,
  input  logic [63:0] m_wdata,
  input  logic        l_req,
  input  logic        l_we,
  input  logic [63:0] l_addr,
  input  logic [63:0] l_wdata,
  output logic        m_done,
  output logic        l_done,
  output logic [63:0] m_rdata,
  output logic [63:0] l_rdata,
  output logic        adr_err,
  output logic        m_stall,
  output logic        busy
);

  localparam int          c_aw         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]  c_starve_max = 3'(STARVE_MAX);
  localparam logic [63:0] c_depth      = 64'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t          r_state;
  logic [2:0]      r_starve_cnt;
  logic            r_we;
  logic            r_win_l;
  logic [63:0]     r_addr;
  logic [63:0]     r_wdata;
  logic [63:0]     r_mem [DEPTH];

  logic            w_any_req;
  logic            w_grant_l;
  logic            w_in_range;
  logic [c_aw-1:0] w_idx;
  logic [63:0]     w_rd;

  assign w_any_req  = m_req | l_req;
  // Memory stage normally wins; the loader takes over once it has been passed over STARVE_MAX times.
  assign w_grant_l  = l_req & (~m_req | (r_starve_cnt == c_starve_max));
  assign w_in_range = (r_addr < c_depth);
  assign w_idx      = r_addr[c_aw-1:0];
  assign w_rd       = w_in_range ? r_mem[w_idx] : 64'd0;

  // Memory is never cleared; a reset landing on the access cycle blocks the write.
  always_ff @(posedge clk) begin
    if (!reset && (r_state == ACCESS) && r_we && w_in_range) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_starve_cnt <= 3'd0;
      r_we         <= 1'b0;
      r_win_l      <= 1'b0;
      r_addr       <= 64'd0;
      r_wdata      <= 64'd0;
      m_done       <= 1'b0;
      l_done       <= 1'b0;
      adr_err      <= 1'b0;
      m_rdata      <= 64'd0;
      l_rdata      <= 64'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_state <= ACCESS;
            r_win_l <= w_grant_l;
            r_we    <= w_grant_l ? l_we    : m_we;
            r_addr  <= w_grant_l ? l_addr  : m_addr;
            r_wdata <= w_grant_l ? l_wdata : m_wdata;
            if (w_grant_l) begin
              r_starve_cnt <= 3'd0;
            end else if (l_req && (r_starve_cnt != c_starve_max)) begin
              r_starve_cnt <= r_starve_cnt + 3'd1;
            end
          end
        end
        ACCESS: begin
          r_state <= RESP;
          adr_err <= ~w_in_range;
          if (r_win_l) begin
            l_done  <= 1'b1;
            l_rdata <= w_rd;
          end else begin
            m_done  <= 1'b1;
            m_rdata <= w_rd;
          end
        end
        RESP: begin
          r_state <= IDLE;
          m_done  <= 1'b0;
          l_done  <= 1'b0;
          adr_err <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_stall = m_req & ~m_done;
  assign busy    = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Self-checking bench for dmem_arbiter against a transaction model.
// Revision : 1.0
// ============================================================================
module tb_dmem_arbiter;

  localparam int DEPTH      = 2048;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_req, m_we, l_req, l_we;
  logic [63:0] m_addr, m_wdata, l_addr, l_wdata;
  logic        m_done, l_done, adr_err, m_stall, busy;
  logic [63:0] m_rdata, l_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk     (clk),
    .reset   (reset),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .l_req   (l_req),
    .l_we    (l_we),
    .l_addr  (l_addr),
    .l_wdata (l_wdata),
    .m_done  (m_done),
    .l_done  (l_done),
    .m_rdata (m_rdata),
    .l_rdata (l_rdata),
    .adr_err (adr_err),
    .m_stall (m_stall),
    .busy    (busy)
  );

  typedef struct {
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    bit          drop;
    int          gap;
  } op_t;

  op_t         mq[$], lq[$];
  op_t         mcur, lcur;
  int          mwait, lwait;
  int          ms, ls;            // requester: 0 idle, 1 waiting, 2 granted
  logic [63:0] ref_mem [DEPTH];
  int          cyc;
  bit          act;
  int          tstart;
  bit          twin_l, twe, terr;
  logic [63:0] trd;
  int          starve;
  bit          done_log[$];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  function automatic op_t mk(bit we, logic [63:0] a, logic [63:0] d, bit drop = 0, int gap = 0);
    op_t o;
    o.we = we; o.addr = a; o.wdata = d; o.drop = drop; o.gap = gap;
    return o;
  endfunction

  // One clock cycle: check DUT outputs for this cycle, drive requesters, advance model.
  task automatic step();
    bit  edm, edl;
    op_t op;
    edm = act && (cyc == tstart + 2) && !twin_l;
    edl = act && (cyc == tstart + 2) && twin_l;
    check("m_done", m_done, edm);
    check("l_done", l_done, edl);
    check("busy", busy, act && (cyc == tstart + 1 || cyc == tstart + 2));
    check("adr_err", adr_err, (edm || edl) ? terr : 1'b0);
    check("m_stall", m_stall, m_req & ~edm);
    if (edm && !twe) check("m_rdata", m_rdata, trd);
    if (edl && !twe) check("l_rdata", l_rdata, trd);
    if (m_done) done_log.push_back(1'b0);
    if (l_done) done_log.push_back(1'b1);

    if (act && cyc == tstart + 3) begin
      if (twin_l) ls = 0; else ms = 0;
      act = 0;
    end
    if (ms == 0 && mq.size() > 0) begin
      if (mq[0].gap > mwait) mwait++;
      else begin mcur = mq.pop_front(); ms = 1; mwait = 0; end
    end
    if (ls == 0 && lq.size() > 0) begin
      if (lq[0].gap > lwait) lwait++;
      else begin lcur = lq.pop_front(); ls = 1; lwait = 0; end
    end
    m_req   = (ms == 1) || (ms == 2 && !(mcur.drop && cyc > tstart));
    m_we    = mcur.we;  m_addr = mcur.addr;  m_wdata = mcur.wdata;
    l_req   = (ls == 1) || (ls == 2 && !(lcur.drop && cyc > tstart));
    l_we    = lcur.we;  l_addr = lcur.addr;  l_wdata = lcur.wdata;

    if (!act && (m_req || l_req)) begin
      twin_l = l_req && (!m_req || starve == STARVE_MAX);
      if (twin_l) begin
        starve = 0; op = lcur; ls = 2;
      end else begin
        if (l_req) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
        op = mcur; ms = 2;
      end
      act    = 1;
      tstart = cyc;
      twe    = op.we;
      terr   = (op.addr >= 64'(DEPTH));
      trd    = terr ? 64'd0 : ref_mem[op.addr[10:0]];
      if (op.we && !terr) ref_mem[op.addr[10:0]] = op.wdata;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run(input int budget);
    int n = 0;
    while ((mq.size() > 0 || lq.size() > 0 || ms != 0 || ls != 0 || act) && n < budget) begin
      step();
      n++;
    end
    vectors++;
    assert (n < budget) else begin
      miscompares++;
      $error("FAIL run_timeout: observed %0d cycles expected fewer than %0d", n, budget);
    end
  endtask

  function automatic logic [63:0] rnd_addr();
    int k = $urandom_range(0, 19);
    if (k < 16)  return 64'(k);
    if (k == 16) return 64'd2047;
    if (k == 17) return 64'd2048;
    if (k == 18) return {$urandom, $urandom} | 64'h8000_0000_0000_0000;
    return 64'd15;
  endfunction

  initial begin
    reset = 1'b1;
    m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0;
    l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0;
    mcur = mk(0, 0, 0); lcur = mk(0, 0, 0);
    ms = 0; ls = 0; mwait = 0; lwait = 0;
    act = 0; tstart = 0; starve = 0; cyc = 0;
    twin_l = 0; twe = 0; terr = 0; trd = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_done", m_done, 1'b0);
    check("rst_l_done", l_done, 1'b0);
    check("rst_adr_err", adr_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_m_rdata", m_rdata, 64'd0);
    check("rst_l_rdata", l_rdata, 64'd0);
    reset = 1'b0;

    // Known contents for every in-range address used later
    for (int i = 0; i < 16; i++) mq.push_back(mk(1, 64'(i), (i == 7) ? 64'h1 : 64'h1000 + 64'(i)));
    mq.push_back(mk(1, 64'd2047, 64'hFEED_0000_0000_07FF));
    run(500);

    // Write then read back through the memory stage
    mq.push_back(mk(1, 64'd5, 64'hDEAD));
    mq.push_back(mk(0, 64'd5, 64'h0));
    run(100);

    // Simultaneous requests: memory stage first, loader three cycles later
    done_log.delete();
    mq.push_back(mk(0, 64'd5, 64'h0));
    lq.push_back(mk(0, 64'd3, 64'h0));
    run(100);
    check("tie_count", done_log.size(), 2);
    check("tie_first_is_m", done_log[0], 1'b0);
    check("tie_second_is_l", done_log[1], 1'b1);

    // Loader starvation limit
    done_log.delete();
    for (int i = 1; i <= 5; i++) mq.push_back(mk(0, 64'(i), 64'h0));
    lq.push_back(mk(0, 64'd10, 64'h0));
    run(200);
    check("starve_count", done_log.size(), 6);
    for (int i = 0; i < 4; i++) check("starve_m_grant", done_log[i], 1'b0);
    check("starve_5th_is_l", done_log[4], 1'b1);
    check("starve_6th_is_m", done_log[5], 1'b0);
    done_log.delete();
    mq.push_back(mk(0, 64'd1, 64'h0));
    lq.push_back(mk(0, 64'd2, 64'h0));
    run(100);
    check("starve_cleared", done_log[0], 1'b0);

    // Address range boundaries, including high bits set above the index field
    mq.push_back(mk(1, 64'd2048, 64'h55));
    mq.push_back(mk(0, 64'd0, 64'h0));
    mq.push_back(mk(1, 64'hFFFF_FFFF_0000_0005, 64'h77));
    mq.push_back(mk(0, 64'd5, 64'h0));
    mq.push_back(mk(0, 64'd2047, 64'h0));
    lq.push_back(mk(0, 64'd2048, 64'h0, 0, 4));
    run(200);

    // Request dropped after acceptance still completes
    mq.push_back(mk(1, 64'd9, 64'hABCD, 1));
    mq.push_back(mk(0, 64'd9, 64'h0));
    run(100);

    // Reset during the access cycle drops the write and the done pulse
    m_we = 1'b1; m_addr = 64'd7; m_wdata = 64'h2; m_req = 1'b1;
    @(posedge clk); #1;
    check("rstacc_busy", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; m_req = 1'b0; m_we = 1'b0;
    check("rstacc_busy_clr", busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("rstacc_no_done", m_done, 1'b0);
      @(posedge clk); #1;
    end
    act = 0; starve = 0; ms = 0; ls = 0; mcur = mk(0, 0, 0); lcur = mk(0, 0, 0);
    mq.push_back(mk(0, 64'd7, 64'h0));
    run(100);

    // Randomised traffic on both ports
    for (int i = 0; i < 40; i++) begin
      mq.push_back(mk($urandom_range(0, 1), rnd_addr(), {$urandom, $urandom},
                      ($urandom_range(0, 7) == 0), $urandom_range(0, 3)));
      lq.push_back(mk($urandom_range(0, 1), rnd_addr(), {$urandom, $urandom},
                      ($urandom_range(0, 7) == 0), $urandom_range(0, 3)));
    end
    run(2000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed no completion, expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The module SHALL have parameter DEPTH, default 2048, which sets the number of 64-bit data memory words.
REQ-002 The module SHALL have parameter STARVE_MAX, default 4, which sets the number of consecutive memory-stage grants allowed while the loader waits.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have ports m_req, m_we (input, 1 bit each) and m_addr, m_wdata (input, 64 bits each): the pipeline memory-stage request, write enable, word address and write data.
REQ-006 The module SHALL have ports l_req, l_we (input, 1 bit each) and l_addr, l_wdata (input, 64 bits each): the same request set for the program loader.
REQ-007 The module SHALL have ports m_done, l_done (output, 1 bit each): one-cycle completion pulses.
REQ-008 The module SHALL have ports m_rdata, l_rdata (output, 64 bits each): read data, valid while the matching done is high.
REQ-009 The module SHALL have port adr_err, output, 1 bit: address-out-of-range flag, valid with done.
REQ-010 The module SHALL have port m_stall, output, 1 bit: pipeline stall request.
REQ-011 The module SHALL have port busy, output, 1 bit: a transaction is in flight.

Function
REQ-012 The module SHALL own a DEPTH x 64-bit word-addressed memory array, indexed by addr[10:0] for the default DEPTH.
REQ-013 The FSM SHALL have states IDLE, ACCESS and RESP, with transitions IDLE->ACCESS on any request and ACCESS->RESP->IDLE unconditionally.
REQ-014 In IDLE with any request, the winner's we/addr/wdata and its identity SHALL be latched.
REQ-015 Arbitration SHALL grant the memory stage, except when l_req=1 and starve_cnt==STARVE_MAX, in which case the loader SHALL be granted.
REQ-016 starve_cnt (3 bits) SHALL increment when the memory stage wins while l_req=1, saturate at STARVE_MAX, and clear when the loader wins.
REQ-017 In ACCESS, for addr < DEPTH (unsigned 64-bit compare), a write SHALL store wdata and a read SHALL capture mem[addr].
REQ-018 In ACCESS, for addr >= DEPTH, the module SHALL perform no write, capture read data = 0 and set the error flag.
REQ-019 In RESP, only the winner's done SHALL pulse for one cycle, with the winner's rdata and adr_err valid.
REQ-020 Latency SHALL be 2 cycles: a request sampled in IDLE at cycle N gives done at N+2, and throughput is one transaction per 3 cycles.
REQ-021 Requesters SHALL hold req and operands stable until done and clear req at the edge where done is sampled; a req high in IDLE is always a new request.
REQ-022 A req deasserted early SHALL NOT abort an accepted transaction, which completes and pulses done.
REQ-023 rdata SHALL hold its last value outside RESP; adr_err SHALL be 0 outside RESP.
REQ-024 m_stall SHALL equal m_req & ~m_done (combinational).
REQ-025 busy SHALL equal (state != IDLE).
REQ-026 Simultaneous m_req and l_req in IDLE SHALL be resolved per REQ-015; the loser waits, and its req stays high.

Reset
REQ-027 When reset=1 at a clock edge, the module SHALL set state=IDLE, starve_cnt=0, all done=0, adr_err=0, rdata=0 and busy=0.
REQ-028 Reset SHALL take priority over every transition; reset in the ACCESS cycle SHALL suppress the write, and no done SHALL issue for the dropped transaction.
REQ-029 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-030 Scenario: after reset, m write addr 5 = 0xDEAD, then m read addr 5 -> m_done at N+2 of each request, m_rdata=0xDEAD, adr_err=0.
REQ-031 Scenario: m_req and l_req rise in the same IDLE cycle -> m_done at N+2, l_done at N+5, never both high together.
REQ-032 Scenario: m_req re-issued back-to-back with l_req held -> 4 m grants, then the 5th grant goes to the loader, then starve_cnt=0.
REQ-033 Scenario: m write addr 2048 data 0x55 -> m_done with adr_err=1; a later read of addr 0 returns its prior value.
REQ-034 Scenario: addr 7 holds 0x1, an m write of 0x2 to addr 7 with reset asserted in ACCESS -> no m_done; a subsequent read of addr 7 returns 0x1.
REQ-035 Scenario: m_stall is 1 from the m_req rise through the cycle before m_done, and 0 in the m_done cycle.
